// File: rtl/vga_timing_if.sv
// Raster timing bundle from the VGA timing generator to the pixel colour logic.
interface vga_timing_if;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       bright;
    logic       hSync;
    logic       vSync;
    logic       pixel_en;
    logic       frame_tick;
    logic       game_tick;

    modport master (
        output hCount, vCount, bright, hSync, vSync,
        output pixel_en, frame_tick, game_tick
    );

    modport slave (
        input hCount, vCount, bright, hSync, vSync,
        input pixel_en, frame_tick, game_tick
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing with a pixel clock-enable divider and frame/game ticks.
// Decoded outputs are registered from the next counter values so all raster signals align.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515,
    parameter int FRAME_DIV   = 1
) (
    input logic         clk,
    input logic         rst,
    vga_timing_if.master vga
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [FW-1:0] frame_div_cnt;
    logic [9:0]    h_nxt;
    logic [9:0]    v_nxt;
    logic          frame_wrap;
    logic          fd_wrap;
    logic          h_end;
    logic          v_end;

    assign vga.pixel_en = (div_cnt == DW'(CLK_DIV - 1));
    assign h_end   = (vga.hCount == 10'(H_TOTAL - 1));
    assign v_end   = (vga.vCount == 10'(V_TOTAL - 1));
    assign fd_wrap = (frame_div_cnt == FW'(FRAME_DIV - 1));

    always_comb begin
        h_nxt      = vga.hCount;
        v_nxt      = vga.vCount;
        frame_wrap = 1'b0;
        if (vga.pixel_en) begin
            if (h_end) begin
                h_nxt = 10'd0;
                if (v_end) begin
                    v_nxt      = 10'd0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = vga.vCount + 10'd1;
                end
            end else begin
                h_nxt = vga.hCount + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt        <= '0;
            frame_div_cnt  <= '0;
            vga.hCount     <= 10'd0;
            vga.vCount     <= 10'd0;
            vga.hSync      <= 1'b0;
            vga.vSync      <= 1'b0;
            vga.bright     <= 1'b0;
            vga.frame_tick <= 1'b0;
            vga.game_tick  <= 1'b0;
        end else begin
            div_cnt <= vga.pixel_en ? '0 : div_cnt + DW'(1);
            vga.hCount <= h_nxt;
            vga.vCount <= v_nxt;
            // Decode from next counts so sync/bright describe the same pixel as the counters
            vga.hSync  <= ~(h_nxt < 10'(H_SYNC));
            vga.vSync  <= ~(v_nxt < 10'(V_SYNC));
            vga.bright <= (h_nxt >= 10'(H_VIS_START)) && (h_nxt < 10'(H_VIS_END)) &&
                          (v_nxt >= 10'(V_VIS_START)) && (v_nxt < 10'(V_VIS_END));
            vga.frame_tick <= frame_wrap;
            vga.game_tick  <= frame_wrap && fd_wrap;
            if (frame_wrap) begin
                frame_div_cnt <= fd_wrap ? '0 : frame_div_cnt + FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: per-config arithmetic raster model, random mid-frame resets.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       b;
        logic       hs;
        logic       vs;
        logic       pe;
        logic       ft;
        logic       gt;
    } snap_t;

    localparam int NCFG = 3;
    localparam int CD[NCFG]    = '{4, 2, 1};
    localparam int HT[NCFG]    = '{800, 20, 10};
    localparam int HS[NCFG]    = '{96, 3, 2};
    localparam int HVS[NCFG]   = '{144, 5, 3};
    localparam int HVE[NCFG]   = '{784, 17, 8};
    localparam int VT[NCFG]    = '{525, 12, 6};
    localparam int VS[NCFG]    = '{2, 2, 1};
    localparam int VVS[NCFG]   = '{35, 3, 1};
    localparam int VVE[NCFG]   = '{515, 10, 5};
    localparam int FD[NCFG]    = '{1, 3, 2};
    localparam int NCYC[NCFG]  = '{9000, 6000, 3000};
    localparam int RSTAT[NCFG] = '{5001, 2503, 1507};
    localparam int RATE[NCFG]  = '{0, 2000, 800};

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // k = clk edges since reset release; the raster follows from pixel count k/CLK_DIV
    function automatic snap_t model(input int g, input int k);
        snap_t s;
        int n, ppf, h, v, f;
        n   = k / CD[g];
        ppf = HT[g] * VT[g];
        h   = n % HT[g];
        v   = (n / HT[g]) % VT[g];
        f   = n / ppf;
        s.h  = h[9:0];
        s.v  = v[9:0];
        s.b  = (h >= HVS[g]) && (h < HVE[g]) && (v >= VVS[g]) && (v < VVE[g]);
        s.hs = !(h < HS[g]);
        s.vs = !(v < VS[g]);
        s.pe = (k % CD[g]) == (CD[g] - 1);
        s.ft = (k % CD[g] == 0) && (n > 0) && (n % ppf == 0);
        s.gt = s.ft && (f % FD[g] == 0);
        return s;
    endfunction

    task automatic cmp(input int g, input string nm, input snap_t a, input snap_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cfg%0d %s t=%0t act h=%0d v=%0d b=%b hs=%b vs=%b pe=%b ft=%b gt=%b req h=%0d v=%0d b=%b hs=%b vs=%b pe=%b ft=%b gt=%b",
                     g, nm, $time, a.h, a.v, a.b, a.hs, a.vs, a.pe, a.ft, a.gt,
                     e.h, e.v, e.b, e.hs, e.vs, e.pe, e.ft, e.gt);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        vga_timing_if vif ();
        logic  rst_g;
        logic  fin = 1'b0;
        snap_t q[$];
        snap_t act;

        assign act = '{h: vif.hCount, v: vif.vCount, b: vif.bright,
                       hs: vif.hSync, vs: vif.vSync, pe: vif.pixel_en,
                       ft: vif.frame_tick, gt: vif.game_tick};

        vga_timing_gen #(
            .CLK_DIV(CD[g]), .H_TOTAL(HT[g]), .H_SYNC(HS[g]),
            .H_VIS_START(HVS[g]), .H_VIS_END(HVE[g]),
            .V_TOTAL(VT[g]), .V_SYNC(VS[g]),
            .V_VIS_START(VVS[g]), .V_VIS_END(VVE[g]),
            .FRAME_DIV(FD[g])
        ) dut (
            .clk(clk),
            .rst(rst_g),
            .vga(vif)
        );

        // Stimulus: advances the model and queues the expected raster after every edge
        initial begin
            int k;
            int hold;
            k = 0;
            hold = 0;
            rst_g = 1'b1;
            #1 cmp(g, "reset", act, model(g, 0));
            repeat (2) @(posedge clk);
            #2 rst_g = 1'b0;
            for (int c = 0; c < NCYC[g]; c++) begin
                @(posedge clk);
                if (!rst_g) k++;
                q.push_back(model(g, k));
                #2;
                if (rst_g) begin
                    hold--;
                    if (hold <= 0) rst_g = 1'b0;
                end else if (c == RSTAT[g] ||
                             (RATE[g] != 0 && $urandom_range(1, RATE[g]) == 1)) begin
                    rst_g = 1'b1;
                    k = 0;
                    q.delete();
                    q.push_back(model(g, 0));
                    #1 cmp(g, "async_rst", act, model(g, 0));
                    hold = $urandom_range(1, 3);
                end
            end
            @(negedge clk);
            #1;
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL cfg%0d drain left=%0d required=0", g, q.size());
            end
            fin = 1'b1;
        end

        // Monitor: compares the presented raster against the oldest queued expectation
        always @(negedge clk) begin
            if (q.size() > 0) cmp(g, "raster", act, q.pop_front());
        end
    end

    initial begin
        fork
            wait (cfg[0].fin && cfg[1].fin && cfg[2].fin);
            #2000000;
        join_any
        if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
            checks++;
            errors++;
            $display("FAIL timeout fin=%b%b%b required=111",
                     cfg[0].fin, cfg[1].fin, cfg[2].fin);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster timing consumed by the per-pixel colour logic: hCount, vCount, bright, hSync and vSync for a 640x480 display at 60 Hz.
- Also produces frame-rate pulses: frame_tick, and a slower game_tick to clock or enable object-movement logic.
- Runs on the single board clock.
- Derives the 25 MHz pixel rate internally with a clock-enable divider; it does not generate a derived clock.

Parameters:
- CLK_DIV, 4, board clocks per pixel (legal >= 1; 1 means pixel_en is permanently high)
- H_TOTAL, 800, pixels per line
- H_SYNC, 96, hSync low width in pixels, starting at hCount 0
- H_VIS_START, 144, first visible hCount
- H_VIS_END, 784, first non-visible hCount after the visible region
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vSync low width in lines, starting at vCount 0
- V_VIS_START, 35, first visible vCount
- V_VIS_END, 515, first non-visible vCount after the visible region
- FRAME_DIV, 1, frames per game_tick (legal >= 1)

Ports:
- clk  input  1  board clock; the only clock in the block
- rst  input  1  asynchronous, active-high reset
- hCount  output  10  current pixel column, 0..H_TOTAL-1
- vCount  output  10  current line, 0..V_TOTAL-1
- bright  output  1  high when the current pixel is in the visible region
- hSync  output  1  horizontal sync, active low
- vSync  output  1  vertical sync, active low
- pixel_en  output  1  one-clk strobe marking each pixel advance
- frame_tick  output  1  one-clk pulse at the start of each frame
- game_tick  output  1  one-clk pulse every FRAME_DIV frames, coincident with frame_tick

Behaviour:
- Clocking and reset: one clock (clk); rst is asynchronous and active-high. All state is in flops on posedge clk / posedge rst.
- Reset values:
  - div_cnt=0, hCount=0, vCount=0, frame_div_cnt=0
  - pixel_en=0, frame_tick=0, game_tick=0, bright=0
  - hSync=0, vSync=0 (these match the decode of count (0,0))
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - pixel_en is combinational: (div_cnt==CLK_DIV-1).
  - After reset release, the first pixel_en occurs on the CLK_DIV-th clk edge.
- Counters, updated only in a cycle where pixel_en=1:
  - hCount==H_TOTAL-1: hCount goes to 0.
    - If vCount==V_TOTAL-1, vCount goes to 0; otherwise vCount increments.
  - Otherwise hCount increments and vCount holds.
  - Counters never exceed TOTAL-1; no other wrap behaviour exists.
- Decoded outputs:
  - hSync, vSync and bright are registered, updated on the same edge as the counters, and computed from the next counter values.
  - Result: all five raster outputs always describe the same pixel, with zero skew between them.
  - hSync = ~(hCount < H_SYNC)
  - vSync = ~(vCount < V_SYNC)
  - bright = (H_VIS_START <= hCount < H_VIS_END) && (V_VIS_START <= vCount < V_VIS_END)
- frame_tick:
  - Registered; high for exactly one clk.
  - Asserted on the edge where the counters transition from (H_TOTAL-1, V_TOTAL-1) to (0,0), so it is high while the counters read (0,0).
  - Not asserted on the initial (0,0) after reset.
- game_tick:
  - frame_div_cnt counts frame_ticks 0..FRAME_DIV-1.
  - game_tick is registered and asserted in the same cycle as frame_tick when frame_div_cnt wraps.
  - With FRAME_DIV=1, game_tick is identical to frame_tick.
- Timing at defaults:
  - line = 800 pixels = 3200 clk
  - frame = 420000 pixels = 1,680,000 clk
- Reset mid-frame: all state returns to reset values immediately (asynchronously), with no partial pulses. The counting sequence restarts exactly as from power-up.
- No inputs other than clk and rst. The block cannot stall and has no back-pressure.

Test Plan:
- Reset release, defaults -> pixel_en high on clk edges 4, 8, 12, ...; hCount steps 0,1,2 one per pixel_en; hSync=0, vSync=0 and bright=0 at (0,0).
- Run one line -> hSync low for hCount 0..95 (384 clk), high at 96; hCount wraps 799->0 and vCount goes 0->1 on the same edge; line period = 3200 clk.
- Visible-edge probes:
  - bright=0 at (143,35), 1 at (144,35), 1 at (783,514)
  - bright=0 at (784,514), (144,515) and (144,34)
- Full frame -> vSync low for vCount 0..1 (1600 pixels); frame_tick exactly one clk wide at the (799,524)->(0,0) transition; consecutive frame_ticks spaced 1,680,000 clk; no frame_tick right after reset.
- FRAME_DIV=3 -> game_tick on the 3rd, 6th, 9th frame_tick only, always coincident with frame_tick; CLK_DIV=1 -> pixel_en constantly 1 and line period = 800 clk.
- Assert rst at (400,200) mid-pixel -> all outputs immediately at reset values; after release the sequence matches the first scenario cycle-for-cycle.
